// File: rtl/demux_sipo.sv
// Serial-to-parallel 1:8 demultiplexer with valid/ack byte output.
// Define DEMUX_SIPO_OVERRUN_EN to build the sticky overrun flag; otherwise overrun is tied low.
module demux_sipo #(
  parameter logic FILL = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in,
  input  logic       in_valid,
  input  logic       mode,
  input  logic [2:0] sel,
  input  logic       clr,
  input  logic       out_ack,
  output logic [7:0] out,
  output logic       out_valid,
  output logic [2:0] ptr,
  output logic       overrun
);

  // state    | meaning
  // ST_IDLE  | no bits captured since the last frame boundary
  // ST_FILL  | at least one bit of the current frame captured
  typedef enum logic {ST_IDLE, ST_FILL} state_t;

  state_t     state;
  logic [7:0] asm_q;
  logic       mode_q;

  logic [2:0] idx;
  logic [7:0] asm_nxt;
  logic       discard;
  logic       capture;
  logic       done;

  always_comb begin
    idx          = mode ? ptr : sel;
    asm_nxt      = asm_q;
    asm_nxt[idx] = in;
    // a mode flip mid-frame throws the partial frame away and swallows that cycle's bit
    discard      = (state == ST_FILL) && (mode != mode_q);
    capture      = in_valid && !discard;
    done         = capture && (idx == 3'd7);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      asm_q     <= {8{FILL}};
      out       <= {8{FILL}};
      out_valid <= 1'b0;
      ptr       <= 3'd0;
      mode_q    <= 1'b0;
    end else begin
      mode_q <= mode;
      if (clr) begin
        state     <= ST_IDLE;
        asm_q     <= {8{FILL}};
        out       <= {8{FILL}};
        out_valid <= 1'b0;
        ptr       <= 3'd0;
      end else begin
        if (out_ack && out_valid)
          out_valid <= 1'b0;
        if (discard) begin
          state <= ST_IDLE;
          asm_q <= {8{FILL}};
          ptr   <= 3'd0;
        end else if (capture) begin
          if (mode)
            ptr <= ptr + 3'd1;
          if (done) begin
            // completion overrides a same-cycle ack
            out       <= asm_nxt;
            out_valid <= 1'b1;
            asm_q     <= {8{FILL}};
            state     <= ST_IDLE;
          end else begin
            asm_q <= asm_nxt;
            state <= ST_FILL;
          end
        end
      end
    end
  end

`ifdef DEMUX_SIPO_OVERRUN_EN
  logic ovr_evt;
  assign ovr_evt = done && out_valid && !out_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      overrun <= 1'b0;
    else if (clr)
      overrun <= 1'b0;
    else if (ovr_evt)
      overrun <= 1'b1;
  end
`else
  assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_demux_sipo.sv
// Directed self-checking bench for demux_sipo; expected overrun follows DEMUX_SIPO_OVERRUN_EN.
module tb_demux_sipo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in;
  logic       in_valid;
  logic       mode;
  logic [2:0] sel;
  logic       clr;
  logic       out_ack;
  logic [7:0] out;
  logic       out_valid;
  logic [2:0] ptr;
  logic       overrun;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef DEMUX_SIPO_OVERRUN_EN
  localparam logic OVR_EXP = 1'b1;
`else
  localparam logic OVR_EXP = 1'b0;
`endif

  demux_sipo dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in        (in),
    .in_valid  (in_valid),
    .mode      (mode),
    .sel       (sel),
    .clr       (clr),
    .out_ack   (out_ack),
    .out       (out),
    .out_valid (out_valid),
    .ptr       (ptr),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic m, input logic [2:0] s, input logic b);
    mode     = m;
    sel      = s;
    in       = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic auto_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++)
      put(1'b1, 3'd0, v[i]);
  endtask

  task automatic ack_pulse();
    out_ack = 1'b1;
    tick();
    out_ack = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in = 1'b0; in_valid = 1'b0; mode = 1'b0;
    sel = 3'd0; clr = 1'b0; out_ack = 1'b0;
    #12;
    check("rst_out", out, 8'h00);
    check("rst_valid", out_valid, 1'b0);
    check("rst_ptr", ptr, 3'd0);
    check("rst_ovr", overrun, 1'b0);
    rst_n = 1'b1;
    tick();

    // auto mode: bits 1,0,1,1,0,0,1,0 -> 8'h4D
    put(1, 0, 1); put(1, 0, 0); put(1, 0, 1); put(1, 0, 1);
    put(1, 0, 0); put(1, 0, 0); put(1, 0, 1);
    check("auto_ptr7", ptr, 3'd7);
    check("auto_pending", out_valid, 1'b0);
    put(1, 0, 0);
    check("auto_out", out, 8'h4D);
    check("auto_valid", out_valid, 1'b1);
    check("auto_ptr_wrap", ptr, 3'd0);
    tick();
    check("auto_hold", out, 8'h4D);

    // handshake
    ack_pulse();
    check("ack_valid", out_valid, 1'b0);
    check("ack_out", out, 8'h4D);
    ack_pulse();
    check("ack_idle_valid", out_valid, 1'b0);

    // addressed mode: sel 0..6 = 1, sel 7 = 0 -> 8'h7F
    for (int i = 0; i < 7; i++) put(0, 3'(i), 1);
    check("addr_pending", out_valid, 1'b0);
    put(0, 7, 0);
    check("addr_out", out, 8'h7F);
    check("addr_valid", out_valid, 1'b1);
    check("addr_ptr", ptr, 3'd0);
    ack_pulse();

    // rewrite sel 3 (1 then 0) keeps the last value -> 8'h77
    for (int i = 0; i < 7; i++) put(0, 3'(i), 1);
    put(0, 3, 0);
    put(0, 7, 0);
    check("rewrite_out", out, 8'h77);
    ack_pulse();

    // overrun: A5 then 3C without ack
    auto_byte(8'hA5);
    check("ovr_first_out", out, 8'hA5);
    check("ovr_first_flag", overrun, 1'b0);
    auto_byte(8'h3C);
    check("ovr_out", out, 8'h3C);
    check("ovr_valid", out_valid, 1'b1);
    check("ovr_flag", overrun, OVR_EXP);
    tick(); tick();
    check("ovr_sticky", overrun, OVR_EXP);
    clr = 1'b1; tick(); clr = 1'b0;
    check("clr_out", out, 8'h00);
    check("clr_valid", out_valid, 1'b0);
    check("clr_ovr", overrun, 1'b0);
    check("clr_ptr", ptr, 3'd0);

    // completion in the same cycle as out_ack
    auto_byte(8'hA5);
    for (int i = 0; i < 7; i++) put(1, 0, 1'(8'h3C >> i));
    out_ack = 1'b1;
    put(1, 0, 1'b0);
    out_ack = 1'b0;
    check("sim_valid", out_valid, 1'b1);
    check("sim_out", out, 8'h3C);
    check("sim_ovr", overrun, 1'b0);

    // clr together with in_valid: nothing captured
    clr = 1'b1;
    put(1, 0, 1);
    clr = 1'b0;
    check("clrin_ptr", ptr, 3'd0);
    check("clrin_out", out, 8'h00);
    check("clrin_valid", out_valid, 1'b0);
    check("clrin_ovr", overrun, 1'b0);

    // mode toggle after 3 auto bits discards the partial frame
    put(1, 0, 1); put(1, 0, 1); put(1, 0, 1);
    check("tog_ptr3", ptr, 3'd3);
    put(0, 7, 1);
    check("tog_ptr", ptr, 3'd0);
    check("tog_ignored", out_valid, 1'b0);
    put(0, 7, 1);
    check("tog_clean", out, 8'h80);
    check("tog_valid", out_valid, 1'b1);
    ack_pulse();
    auto_byte(8'h4D);
    check("tog_auto", out, 8'h4D);

    // asynchronous reset mid-frame
    put(1, 0, 1); put(1, 0, 0); put(1, 0, 1);
    check("arst_pre_ptr", ptr, 3'd3);
    #3 rst_n = 1'b0;
    #1;
    check("arst_out", out, 8'h00);
    check("arst_valid", out_valid, 1'b0);
    check("arst_ptr", ptr, 3'd0);
    check("arst_ovr", overrun, 1'b0);
    #2 rst_n = 1'b1;
    tick();
    put(0, 7, 1);
    check("arst_after", out, 8'h80);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/demux_sipo.md
# demux_sipo

Serial-to-parallel 1:8 demultiplexer: the receive-side counterpart of the team's 8:1 mux serialiser. It steers a 1-bit input stream into an 8-bit assembly register, either at an externally supplied select or at an internal auto-incrementing pointer. It presents each completed byte on a registered output with a valid/ack handshake. It sits at the far end of a mux-driven serial link and feeds byte-wide logic.

## Interface
Parameters:
- FILL, 1'b0: value loaded into every assembly/output bit on reset, clr, and frame discard.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in  in  1  serial data bit.
- in_valid  in  1  `in` is sampled this cycle.
- mode  in  1  0 = addressed (bit goes to `sel`), 1 = auto (bit goes to internal pointer).
- sel  in  3  target bit index in addressed mode; ignored in auto mode.
- clr  in  1  synchronous clear of frame state, output and flags.
- out_ack  in  1  consumer has taken `out`.
- out  out  8  last completed byte, registered.
- out_valid  out  1  `out` holds an unconsumed byte.
- ptr  out  3  auto-mode pointer: the next bit index.
- overrun  out  1  sticky overrun flag (see Configuration).

## Operation
- Internal state: asm[7:0], ptr[2:0], mode_q (registered mode), and state in {IDLE, FILL}.
- IDLE: no bits captured since the last frame boundary. Any in_valid moves to FILL, unless that bit completes the frame.
- FILL: one or more bits captured. Frame completion returns to IDLE.
- Auto mode:
  - in_valid writes asm[ptr] <= in, then ptr <= ptr+1 (mod 8).
  - The bit written at ptr==7 completes the frame; ptr wraps to 0.
- Addressed mode:
  - in_valid writes asm[sel] <= in; ptr is unchanged.
  - A write with sel==7 completes the frame; earlier indices may be skipped or rewritten.
- Frame completion:
  - out <= asm with the completing bit merged in; out_valid <= 1.
  - asm <= {8{FILL}}; state <= IDLE.
- out_ack while out_valid==1 clears out_valid; out_ack while out_valid==0 is ignored.
- Mode change (mode != mode_q) while in FILL discards the partial frame: asm <= FILL, ptr <= 0, state <= IDLE. In that cycle in_valid is ignored. `out` and out_valid are untouched.
- clr has highest priority:
  - asm and out go to FILL; ptr <= 0; out_valid <= 0; overrun <= 0; state <= IDLE.
  - in_valid and out_ack in that cycle are ignored.

## Timing
- Reset values: out = {8{FILL}}, out_valid = 0, ptr = 0, overrun = 0, state = IDLE, mode_q = 0.
- Latency: out and out_valid update on the clock edge that samples the completing bit, visible the next cycle.
- Throughput: one bit per cycle; back-to-back frames with no bubbles.
- Completion and out_ack in the same cycle: the completion wins. out_valid stays 1 and holds the new byte; no overrun.
- Completion with out_valid==1 and no out_ack: the new byte overwrites out and out_valid stays 1. The overrun condition fires.
- Asynchronous reset mid-frame discards all state immediately. Reset release must be synchronised externally.

## Configuration
- DEMUX_SIPO_OVERRUN_EN defined:
  - overrun is set on the overrun condition and stays set until clr or reset.
  - It is visible the cycle after the offending completion.
- DEMUX_SIPO_OVERRUN_EN undefined:
  - No overrun logic is built; overrun is tied to 0.
  - The overwrite behaviour is unchanged.

## Test plan
- Auto mode: drive bits 1,0,1,1,0,0,1,0 on in (index 0 first), in_valid held high, then idle. Required: out = 8'h4D with out_valid = 1 one cycle after the 8th bit; ptr = 0.
- Addressed mode: write sel=0..6 with in=1, then sel=7 with in=0. Required: out = 8'h7F. Rewriting sel=3 twice keeps only the last value.
- Handshake: after a frame, pulse out_ack. Required: out_valid falls the next cycle and out holds 8'h4D.
- Overrun: stream two frames 8'hA5 then 8'h3C without out_ack. Required: out = 8'h3C and out_valid = 1. With the macro, overrun = 1 until clr; without it, overrun = 0.
- Simultaneous events: complete a frame in the same cycle as out_ack. Required: out_valid stays 1 and overrun stays 0. clr together with in_valid: nothing is captured and all outputs return to reset values.
- Disruptions: toggle mode after 3 auto bits. Required: ptr = 0, and the next 8 bits form a clean byte. Assert rst_n low mid-frame: all outputs return to reset values asynchronously.
